// File: rtl/load_store_extend_controller.sv
// Load/store sequencer between the MEM pipeline register and data memory.
// Ports: Clk/Reset; Req/Op/Addr/WData in; Mem* memory side; RData/Done/Busy/Err* out.
module load_store_extend_controller #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic [2:0]  Op,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    input  logic [31:0] MemRData,
    input  logic        MemReady,
    output logic        MemEn,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [3:0]  MemByteEn,
    output logic [31:0] MemWData,
    output logic [31:0] RData,
    output logic        Done,
    output logic        Busy,
    output logic        ErrMisalign,
    output logic        ErrTimeout
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_RESP  = 3'd2;
    localparam logic [2:0] S_ERR   = 3'd3;
    localparam logic [2:0] S_TOUT  = 3'd4;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    localparam logic [7:0] T_LAST = 8'(TIMEOUT - 1);

    logic [2:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        emis_q, emis_d;
    logic        eto_q, eto_d;

    logic        req_mis;
    logic        st_q;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ext;
    logic [3:0]  be;
    logic [31:0] wd;

    // Alignment check on the incoming request (byte ops never misalign).
    always_comb begin
        req_mis = 1'b0;
        unique case (Op)
            OP_LW, OP_SW:         req_mis = |Addr[1:0];
            OP_LH, OP_LHU, OP_SH: req_mis = Addr[0];
            default:              req_mis = 1'b0;
        endcase
    end

    assign st_q = (op_q == OP_SW) || (op_q == OP_SH) || (op_q == OP_SB);

    // Little-endian lane selection from the latched address.
    always_comb begin
        lane_b = MemRData[7:0];
        unique case (addr_q[1:0])
            2'd0: lane_b = MemRData[7:0];
            2'd1: lane_b = MemRData[15:8];
            2'd2: lane_b = MemRData[23:16];
            2'd3: lane_b = MemRData[31:24];
            default: lane_b = MemRData[7:0];
        endcase
    end

    assign lane_h = addr_q[1] ? MemRData[31:16] : MemRData[15:0];

    always_comb begin
        ext = 32'd0;
        unique case (op_q)
            OP_LW:   ext = MemRData;
            OP_LH:   ext = {{16{lane_h[15]}}, lane_h};
            OP_LHU:  ext = {16'd0, lane_h};
            OP_LB:   ext = {{24{lane_b[7]}}, lane_b};
            OP_LBU:  ext = {24'd0, lane_b};
            default: ext = 32'd0;
        endcase
    end

    // Lane enables and replicated store data for the latched access.
    always_comb begin
        be = 4'b1111;
        wd = 32'd0;
        unique case (op_q)
            OP_LH, OP_LHU: be = addr_q[1] ? 4'b1100 : 4'b0011;
            OP_LB, OP_LBU: be = 4'b0001 << addr_q[1:0];
            OP_SW: begin
                be = 4'b1111;
                wd = wdata_q;
            end
            OP_SH: begin
                be = addr_q[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata_q[15:0]}};
            end
            OP_SB: begin
                be = 4'b0001 << addr_q[1:0];
                wd = {4{wdata_q[7:0]}};
            end
            default: be = 4'b1111;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        emis_d  = emis_q;
        eto_d   = eto_q;
        unique case (state_q)
            S_IDLE: begin
                if (Req) begin
                    op_d    = Op;
                    addr_d  = Addr;
                    wdata_d = WData;
                    cnt_d   = 8'd0;
                    if (req_mis) begin
                        state_d = S_ERR;
                        rdata_d = 32'd0;
                        emis_d  = 1'b1;
                        eto_d   = 1'b0;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // A ready on the last allowed cycle still completes normally.
                if (MemReady) begin
                    state_d = S_RESP;
                    rdata_d = st_q ? 32'd0 : ext;
                    emis_d  = 1'b0;
                    eto_d   = 1'b0;
                end else if (cnt_q == T_LAST) begin
                    state_d = S_TOUT;
                    rdata_d = 32'd0;
                    emis_d  = 1'b0;
                    eto_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP, S_ERR, S_TOUT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            op_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            emis_q  <= 1'b0;
            eto_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            emis_q  <= emis_d;
            eto_q   <= eto_d;
        end
    end

    // Strobes are pure state decodes so reset removes them asynchronously.
    assign MemEn       = (state_q == S_ISSUE);
    assign MemWe       = MemEn && st_q;
    assign MemAddr     = {addr_q[31:2], 2'b00};
    assign MemByteEn   = MemEn ? be : 4'b0000;
    assign MemWData    = MemEn ? wd : 32'd0;
    assign RData       = rdata_q;
    assign Done        = (state_q == S_RESP) || (state_q == S_ERR) ||
                         (state_q == S_TOUT);
    assign Busy        = (state_q != S_IDLE);
    assign ErrMisalign = emis_q;
    assign ErrTimeout  = eto_q;

endmodule
